// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and constants used by the write-back path.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of write-back entries; also exposes its contents head-first
// so the forwarding logic can search every pending write.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wb_entry_t                entry_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [CW-1:0]            count_o,
  output logic [DEPTH*ENTRY_W-1:0] entries_o,
  output logic [DEPTH-1:0]         valid_o
);

  wb_entry_t     mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   ptr_diff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible once its pointer says so.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[PW-1:0]] <= entry_i;
  end

  assign ptr_diff = wr_ptr - rd_ptr;
  assign count_o  = CW'(ptr_diff);
  assign empty_o  = (wr_ptr == rd_ptr);
  assign full_o   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_o   = mem[rd_ptr[PW-1:0]];

  // Slot i of the flattened view is the i-th oldest entry (slot 0 = head).
  always_comb begin
    entries_o = '0;
    valid_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i*ENTRY_W +: ENTRY_W] = mem[rd_ptr[PW-1:0] + PW'(i)];
      valid_o[i] = ((PW+1)'(i) < ptr_diff);
    end
  end

endmodule

// File: rtl/mips_wb_ctrl.sv
// Write-back controller: queues pipeline write-backs, arbitrates the register
// file write port against load returns, and forwards pending values to readers.
module mips_wb_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              rf_we3_o,
  output logic [ADDR_W-1:0] rf_addr3_o,
  output logic [DATA_W-1:0] rf_wd3_o,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  input  logic [DATA_W-1:0] rf_rd1_i,
  input  logic [DATA_W-1:0] rf_rd2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic [CW-1:0]     pending_o
);

  wb_entry_t                head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     ld_go;
  logic [DEPTH*ENTRY_W-1:0] entries;
  logic [DEPTH-1:0]         entries_vld;

  // Handshake: a request transfers on a rising edge where wb_valid_i and
  // wb_ready_o are both high; ready depends only on registered occupancy, never
  // on a same-cycle pop. Transfers to register 0 are consumed but not queued.
  assign wb_ready_o = !fifo_full;
  assign fifo_push  = wb_valid_i && !fifo_full && (wb_addr_i != ZERO_REG);

  // A load return to r0 writes nothing, so it does not block draining.
  assign ld_go    = rst_ni && ld_we_i && (ld_addr_i != ZERO_REG);
  assign fifo_pop = !fifo_empty && !ld_go;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (fifo_push),
    .entry_i   ('{addr: wb_addr_i, data: wb_data_i}),
    .pop_i     (fifo_pop),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (pending_o),
    .entries_o (entries),
    .valid_o   (entries_vld)
  );

  always_comb begin
    rf_we3_o   = 1'b0;
    rf_addr3_o = '0;
    rf_wd3_o   = '0;
    if (ld_go) begin
      rf_we3_o   = 1'b1;
      rf_addr3_o = ld_addr_i;
      rf_wd3_o   = ld_data_i;
    end else if (!fifo_empty) begin
      rf_we3_o   = 1'b1;
      rf_addr3_o = head.addr;
      rf_wd3_o   = head.data;
    end
  end

  // Queue entries commit after any concurrent load write, so the youngest queue
  // match outranks the load, which outranks the raw register file value.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0]        ra,
    input logic [DATA_W-1:0]        raw,
    input logic [DEPTH*ENTRY_W-1:0] ents,
    input logic [DEPTH-1:0]         vld,
    input logic                     ld_en,
    input logic [ADDR_W-1:0]        ld_addr,
    input logic [DATA_W-1:0]        ld_data
  );
    wb_entry_t e;
    fwd = raw;
    if (ld_en && (ld_addr == ra)) fwd = ld_data;
    for (int i = 0; i < DEPTH; i++) begin
      e = ents[i*ENTRY_W +: ENTRY_W];
      if (vld[i] && (e.addr == ra)) fwd = e.data;
    end
    if (ra == ZERO_REG) fwd = '0;
  endfunction

  always_comb begin
    rd1_o = fwd(rd_addr1_i, rf_rd1_i, entries, entries_vld, ld_go, ld_addr_i, ld_data_i);
    rd2_o = fwd(rd_addr2_i, rf_rd2_i, entries, entries_vld, ld_go, ld_addr_i, ld_data_i);
  end

endmodule

// File: tb/tb_mips_wb_ctrl.sv
// Directed bench for mips_wb_ctrl: queue commits are scoreboarded against an
// expected queue by a negedge monitor; other outputs are checked directly.
module tb_mips_wb_ctrl;

  logic        clk_tb = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ld_we;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        rf_we3;
  logic [4:0]  rf_addr3;
  logic [31:0] rf_wd3;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [1:0]  pending;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];

  mips_wb_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk_i      (clk_tb),
    .rst_ni     (rst_n),
    .wb_valid_i (wb_valid),
    .wb_ready_o (wb_ready),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .ld_we_i    (ld_we),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .rf_we3_o   (rf_we3),
    .rf_addr3_o (rf_addr3),
    .rf_wd3_o   (rf_wd3),
    .rd_addr1_i (rd_addr1),
    .rd_addr2_i (rd_addr2),
    .rf_rd1_i   (rf_rd1),
    .rf_rd2_i   (rf_rd2),
    .rd1_o      (rd1),
    .rd2_o      (rd2),
    .pending_o  (pending)
  );

  // Clock / watchdog
  always #5 clk_tb = ~clk_tb;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input bit expect_commit);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    if (expect_commit) exp_q.push_back({a, d});
    step();
    wb_valid = 1'b0;
  endtask

  // Monitor / scoreboard: every write-port write is either the load path or the
  // next expected queue commit.
  always @(negedge clk_tb) begin
    if (rf_we3 === 1'b1) begin
      if (rst_n && ld_we && ld_addr != 5'd0) begin
        check("ld_port", {27'd0, rf_addr3, rf_wd3}, {27'd0, ld_addr, ld_data});
      end else if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %0h, required no write", rf_addr3, rf_wd3);
      end else begin
        check("commit", {27'd0, rf_addr3, rf_wd3}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd0;
    rf_rd1   = 32'h1234;
    rf_rd2   = 32'h5678;

    // Reset state
    repeat (2) step();
    check("rst_pending", pending, 0);
    check("rst_ready", wb_ready, 1);
    check("rst_we", rf_we3, 0);
    check("rst_addr3", rf_addr3, 0);
    check("rst_wd3", rf_wd3, 0);
    check("rst_rd1_raw", rd1, 32'h1234);
    check("rst_rd2_zero", rd2, 0);
    rst_n = 1'b1;
    step();

    // Basic write
    push(5'd20, 32'h0000_1010, 1'b1);
    check("basic_we", rf_we3, 1);
    check("basic_addr", rf_addr3, 20);
    check("basic_wd", rf_wd3, 32'h0000_1010);
    check("basic_pending", pending, 1);
    rd_addr1 = 5'd20;
    rf_rd1   = 32'h0;
    #1 check("basic_fwd", rd1, 32'h0000_1010);
    step();
    check("basic_idle_we", rf_we3, 0);
    check("basic_idle_pending", pending, 0);

    // Zero register
    wb_valid = 1'b1;
    wb_addr  = 5'd0;
    wb_data  = 32'hDEAD_BEEF;
    #1 check("zero_ready", wb_ready, 1);
    step();
    wb_valid = 1'b0;
    check("zero_we", rf_we3, 0);
    check("zero_pending", pending, 0);
    rd_addr1 = 5'd0;
    rf_rd1   = 32'hFFFF_FFFF;
    #1 check("zero_rd1", rd1, 0);

    // Fill under load stall
    ld_we   = 1'b1;
    ld_addr = 5'd3;
    ld_data = 32'h33;
    push(5'd1, 32'h11, 1'b1);
    push(5'd2, 32'h22, 1'b1);
    check("fill_pending", pending, 2);
    check("fill_ready", wb_ready, 0);
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    wb_data  = 32'h99;
    #1 check("fill_third_ready", wb_ready, 0);
    step();
    wb_valid = 1'b0;
    check("fill_third_pending", pending, 2);
    ld_we = 1'b0;
    #1 check("drain1_addr", rf_addr3, 1);
    step();
    check("drain2_addr", rf_addr3, 2);
    check("drain2_wd", rf_wd3, 32'h22);
    step();
    check("drain_we", rf_we3, 0);
    check("drain_ready", wb_ready, 1);
    check("drain_pending", pending, 0);

    // Forwarding priority
    ld_we    = 1'b1;
    ld_addr  = 5'd4;
    ld_data  = 32'hC;
    rd_addr2 = 5'd4;
    rf_rd2   = 32'h55;
    #1 check("fwd_ld_only", rd2, 32'hC);
    push(5'd4, 32'hA, 1'b1);
    rd_addr1 = 5'd4;
    rf_rd1   = 32'h0;
    #1 check("fwd_one_entry", rd1, 32'hA);
    push(5'd4, 32'hB, 1'b1);
    rd_addr2 = 5'd9;
    rf_rd2   = 32'h99;
    #1 check("fwd_youngest", rd1, 32'hB);
    check("fwd_rd2_raw", rd2, 32'h99);
    ld_we = 1'b0;
    step();
    check("fwd_head_only", rd1, 32'hB);
    step();
    rf_rd1 = 32'h77;
    #1 check("fwd_drained", rd1, 32'h77);

    // Simultaneous push/pop
    push(5'd6, 32'h66, 1'b1);
    push(5'd7, 32'h77, 1'b1);
    check("pp_pending", pending, 1);
    check("pp_head_addr", rf_addr3, 7);
    step();
    check("pp_done_pending", pending, 0);
    check("pp_done_we", rf_we3, 0);

    // Reset mid-operation
    ld_we   = 1'b1;
    ld_addr = 5'd3;
    ld_data = 32'h33;
    push(5'd8, 32'h88, 1'b0);
    push(5'd9, 32'h99, 1'b0);
    check("mid_pending", pending, 2);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_we", rf_we3, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_ready", wb_ready, 1);
    ld_we = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    check("mid_after_pending", pending, 0);

    // Final report
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
